// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: tracks EXE/MEM destination info to pick operand forward
// sources, raise load-use stalls, and count stall cycles.
module hazard_forward_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             flush,
  output logic             DEPEN,
  output logic [1:0]       A_DEPEN,
  output logic [1:0]       B_DEPEN,
  output logic             exe_load,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0]       r_ern;
  logic             r_ewreg;
  logic             r_em2reg;
  logic [4:0]       r_mrn;
  logic             r_mwreg;
  logic             r_mm2reg;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_bubble;
  logic             w_hit_rs;
  logic             w_hit_rt;

  // An EXE-stage load cannot forward yet, so a matching source falls through to MEM.
  function automatic logic [1:0] fwd_sel(
    input logic       use_src,
    input logic [4:0] src,
    input logic [4:0] ern,
    input logic       ewreg,
    input logic       em2reg,
    input logic [4:0] mrn,
    input logic       mwreg,
    input logic       mm2reg
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && (src != 5'd0)) begin
      if (ewreg && !em2reg && (ern == src)) begin
        sel = 2'b01;
      end else if (mwreg && (mrn == src)) begin
        sel = mm2reg ? 2'b11 : 2'b10;
      end else begin
        sel = 2'b00;
      end
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign exe_load  = r_ewreg & r_em2reg;
  assign w_hit_rs  = id_use_rs & (r_ern == id_rs);
  assign w_hit_rt  = id_use_rt & (r_ern == id_rt);
  assign DEPEN     = exe_load & (r_ern != 5'd0) & (w_hit_rs | w_hit_rt);
  assign w_bubble  = DEPEN | flush;
  assign stall_cnt = r_stall_cnt;

  // Forward source selection for both operands.
  always_comb begin
    A_DEPEN = fwd_sel(id_use_rs, id_rs, r_ern, r_ewreg, r_em2reg, r_mrn, r_mwreg, r_mm2reg);
    B_DEPEN = fwd_sel(id_use_rt, id_rt, r_ern, r_ewreg, r_em2reg, r_mrn, r_mwreg, r_mm2reg);
  end

  // Shadow pipeline: MEM takes EXE, EXE takes ID or a bubble on stall/flush.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ern    <= 5'd0;
      r_ewreg  <= 1'b0;
      r_em2reg <= 1'b0;
      r_mrn    <= 5'd0;
      r_mwreg  <= 1'b0;
      r_mm2reg <= 1'b0;
    end else begin
      r_mrn    <= r_ern;
      r_mwreg  <= r_ewreg;
      r_mm2reg <= r_em2reg;
      if (w_bubble) begin
        r_ern    <= 5'd0;
        r_ewreg  <= 1'b0;
        r_em2reg <= 1'b0;
      end else begin
        r_ern    <= id_rn;
        r_ewreg  <= id_wreg;
        r_em2reg <= id_m2reg;
      end
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (DEPEN && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: a 16-bit counter instance and a
// 2-bit counter instance share stimulus so saturation is reachable.
module tb_hazard_forward_unit;

  logic        clock;
  logic        resetn;
  logic [4:0]  id_rs, id_rt, id_rn;
  logic        id_use_rs, id_use_rt, id_wreg, id_m2reg, flush;
  logic        DEPEN, exe_load;
  logic [1:0]  A_DEPEN, B_DEPEN;
  logic [15:0] stall_cnt;
  logic        dep_s, el_s;
  logic [1:0]  a_s, b_s;
  logic [1:0]  stall_cnt_s;
  logic [29:0] got_v;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rn;
    logic       wreg;
    logic       m2;
    logic       fl;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       ed;
    logic       el;
  } row_t;

  logic [29:0] exp_q[$];
  logic [15:0] model_cnt;
  logic [1:0]  model_cnt_s;
  logic        pend_dep;

  hazard_forward_unit #(.CNT_W(16)) dut (
    .clock(clock), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rn(id_rn),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .flush(flush),
    .DEPEN(DEPEN), .A_DEPEN(A_DEPEN), .B_DEPEN(B_DEPEN),
    .exe_load(exe_load), .stall_cnt(stall_cnt)
  );

  hazard_forward_unit #(.CNT_W(2)) dut_sat (
    .clock(clock), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rn(id_rn),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .flush(flush),
    .DEPEN(dep_s), .A_DEPEN(a_s), .B_DEPEN(b_s),
    .exe_load(el_s), .stall_cnt(stall_cnt_s)
  );

  assign got_v = {A_DEPEN, B_DEPEN, DEPEN, exe_load, a_s, b_s, dep_s, el_s, stall_cnt, stall_cnt_s};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic row_t mk(
    input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
    input logic [4:0] rn, input logic wreg, input logic m2, input logic fl,
    input logic [1:0] ea, input logic [1:0] eb, input logic ed, input logic el
  );
    row_t r;
    r = '{rs: rs, rt: rt, urs: urs, urt: urt, rn: rn, wreg: wreg, m2: m2, fl: fl,
          ea: ea, eb: eb, ed: ed, el: el};
    return r;
  endfunction

  task automatic drive_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_rn = 5'd0; id_wreg = 1'b0; id_m2reg = 1'b0; flush = 1'b0;
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
    if (pend_dep) begin
      model_cnt = model_cnt + 16'd1;
      if (model_cnt_s != 2'b11) model_cnt_s = model_cnt_s + 2'd1;
    end
    pend_dep = 1'b0;
  endtask

  task automatic idle();
    advance();
    drive_idle();
  endtask

  task automatic do_step(input row_t r);
    advance();
    id_rs = r.rs; id_rt = r.rt; id_use_rs = r.urs; id_use_rt = r.urt;
    id_rn = r.rn; id_wreg = r.wreg; id_m2reg = r.m2; flush = r.fl;
    exp_q.push_back({r.ea, r.eb, r.ed, r.el, r.ea, r.eb, r.ed, r.el, model_cnt, model_cnt_s});
    pend_dep = r.ed;
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [29:0] e;
    resetn = 1'b0;
    id_rs = 5'd3; id_rt = 5'd3; id_use_rs = 1'b1; id_use_rt = 1'b1;
    id_rn = 5'd3; id_wreg = 1'b1; id_m2reg = 1'b1; flush = 1'b0;
    model_cnt = 16'd0; model_cnt_s = 2'd0; pend_dep = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    exp_q.push_back(30'd0);
    e = exp_q.pop_front();
    checks++;
    if (got_v !== e) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", got_v, e);
    end
    drive_idle();
    resetn = 1'b1;
  endtask

  task automatic test_alu_fwd();
    row_t rows[3];
    logic [29:0] e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[1] = mk(5'd3, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    rows[2] = mk(5'd3, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 3; i++) begin
      do_step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (got_v !== e) begin
        failures++;
        $display("FAIL alu_fwd step%0d got=%h exp=%h", i, got_v, e);
      end
    end
  endtask

  task automatic test_load_mem();
    row_t rows[3];
    logic [29:0] e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    rows[2] = mk(5'd0, 5'd4, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 3; i++) begin
      do_step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (got_v !== e) begin
        failures++;
        $display("FAIL load_mem step%0d got=%h exp=%h", i, got_v, e);
      end
    end
  endtask

  task automatic test_load_use();
    row_t rows[6];
    logic [29:0] e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[1] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    rows[2] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0);
    rows[3] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[4] = mk(5'd9, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    rows[5] = mk(5'd9, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 6; i++) begin
      do_step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (got_v !== e) begin
        failures++;
        $display("FAIL load_use step%0d got=%h exp=%h", i, got_v, e);
      end
    end
  endtask

  task automatic test_priority_r0();
    row_t rows[6];
    logic [29:0] e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[2] = mk(5'd6, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    rows[3] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[4] = mk(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    rows[5] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 6; i++) begin
      do_step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (got_v !== e) begin
        failures++;
        $display("FAIL priority_r0 step%0d got=%h exp=%h", i, got_v, e);
      end
    end
  endtask

  task automatic test_flush();
    row_t rows[5];
    logic [29:0] e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[1] = mk(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[2] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[3] = mk(5'd10, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
    rows[4] = mk(5'd10, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 5; i++) begin
      do_step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (got_v !== e) begin
        failures++;
        $display("FAIL flush step%0d got=%h exp=%h", i, got_v, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[5];
    logic [29:0] e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[1] = mk(5'd11, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    rows[2] = mk(5'd11, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0);
    rows[3] = mk(5'd0, 5'd12, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    rows[4] = mk(5'd0, 5'd12, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 5; i++) begin
      do_step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (got_v !== e) begin
        failures++;
        $display("FAIL back_to_back step%0d got=%h exp=%h", i, got_v, e);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t rows[4];
    logic [29:0] e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[1] = mk(5'd13, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    rows[2] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rows[3] = mk(5'd14, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 2; i++) begin
      do_step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (got_v !== e) begin
        failures++;
        $display("FAIL mid_stall step%0d got=%h exp=%h", i, got_v, e);
      end
    end
    #2;
    resetn = 1'b0;
    #1;
    model_cnt = 16'd0; model_cnt_s = 2'd0; pend_dep = 1'b0;
    exp_q.push_back(30'd0);
    e = exp_q.pop_front();
    checks++;
    if (got_v !== e) begin
      failures++;
      $display("FAIL mid_stall_reset got=%h exp=%h", got_v, e);
    end
    #1;
    resetn = 1'b1;
    for (int i = 2; i < 4; i++) begin
      do_step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (got_v !== e) begin
        failures++;
        $display("FAIL post_reset step%0d got=%h exp=%h", i, got_v, e);
      end
    end
  endtask

  initial begin
    drive_idle();
    resetn = 1'b0;
    model_cnt = 16'd0; model_cnt_s = 2'd0; pend_dep = 1'b0;
    test_reset();
    test_alu_fwd();
    test_load_mem();
    test_load_use();
    test_priority_r0();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall event counter.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port id_rs, input, 5: ID-stage source register A number.
REQ-005 SHALL have port id_rt, input, 5: ID-stage source register B number.
REQ-006 SHALL have port id_use_rs, input, 1: ID instruction reads rs.
REQ-007 SHALL have port id_use_rt, input, 1: ID instruction reads rt.
REQ-008 SHALL have port id_rn, input, 5: ID instruction destination register.
REQ-009 SHALL have port id_wreg, input, 1: ID instruction writes the register file.
REQ-010 SHALL have port id_m2reg, input, 1: ID instruction is a load (result from memory).
REQ-011 SHALL have port flush, input, 1: taken branch/jump; squash the ID instruction.
REQ-012 SHALL have port DEPEN, output, 1: load-use stall request; freeze PC and IF/ID.
REQ-013 SHALL have port A_DEPEN, output, 2: operand A forward select.
REQ-014 SHALL have port B_DEPEN, output, 2: operand B forward select.
REQ-015 SHALL have port exe_load, output, 1: EXE stage holds a valid load.
REQ-016 SHALL have port stall_cnt, output, CNT_W: count of stall cycles.

Function
REQ-017 SHALL hold shadow registers E (ern, ewreg, em2reg) and M (mrn, mwreg, mm2reg) that mirror the destination info of the EXE and MEM stages.
REQ-018 SHALL, each rising edge: M <= E; E <= ID inputs, or a bubble (ewreg=0, em2reg=0, ern=0) when DEPEN=1 or flush=1.
REQ-019 SHALL drive exe_load = ewreg & em2reg, combinationally from E.
REQ-020 SHALL select A_DEPEN combinationally: 01 (EXE ALU result) if id_use_rs & ewreg & ~em2reg & ern==id_rs & ern!=0.
REQ-021 SHALL otherwise select A_DEPEN 10 (MEM ALU result) if id_use_rs & mwreg & ~mm2reg & mrn==id_rs & mrn!=0.
REQ-022 SHALL otherwise select A_DEPEN 11 (MEM load data) if id_use_rs & mwreg & mm2reg & mrn==id_rs & mrn!=0; else 00 (register file).
REQ-023 SHALL derive B_DEPEN with the rules of REQ-020..022, using id_rt and id_use_rt.
REQ-024 SHALL give EXE-stage matches priority over MEM-stage matches when both match.
REQ-025 SHALL never forward or stall on register 0.
REQ-026 SHALL assert DEPEN = exe_load & ern!=0 & ((id_use_rs & ern==id_rs) | (id_use_rt & ern==id_rt)), combinationally.
REQ-027 SHALL, while DEPEN=1, drive the A_DEPEN/B_DEPEN values computed by REQ-020..024; the stalled ID instruction is reissued next cycle.
REQ-028 SHALL apply flush priority over DEPEN; both bubble E and neither changes M.
REQ-029 SHALL increment stall_cnt on each rising edge with DEPEN=1; it saturates at all-ones and does not wrap.
REQ-030 SHALL give a load-use hazard a latency of exactly one stall cycle; the next cycle forwards 11.

Reset
REQ-031 SHALL, while resetn=0, clear E, M and stall_cnt to 0 immediately, regardless of clock.
REQ-032 SHALL, during reset, output exe_load=0 and DEPEN=0; A_DEPEN and B_DEPEN are 00 for any ID inputs.
REQ-033 SHALL make the first clock edge after resetn rises load E from the ID inputs normally.
REQ-034 SHALL clear E, M and stall_cnt when reset is asserted mid-stall, dropping DEPEN in the same cycle.

Verification
REQ-035 SHALL pass: add r3 (id_rn=3, wreg=1), then next cycle id_rs=3 -> A_DEPEN=01, DEPEN=0.
REQ-036 SHALL pass: lw r4, then independent op, then id_rt=4 -> B_DEPEN=11, DEPEN=0.
REQ-037 SHALL pass: lw r5, then next cycle id_rs=5 -> DEPEN=1 for 1 cycle, stall_cnt 0->1; the reissued cycle gives A_DEPEN=11, DEPEN=0.
REQ-038 SHALL pass: E and M both write r6, id_rs=id_rt=6 -> A_DEPEN=B_DEPEN=01; the same case with r0 -> 00/00, DEPEN=0.
REQ-039 SHALL pass: lw r7 issued with flush=1, then id_rs=7 -> exe_load=0, DEPEN=0, A_DEPEN=00.
REQ-040 SHALL pass: preload stall_cnt to FFFE with CNT_W=16 and hold a stall 3 cycles -> stall_cnt=FFFF; resetn=0 mid-stall -> stall_cnt=0000 and DEPEN=0 at once.
